// File: rtl/scr1_wb_pkg.sv
// scr1_wb_pkg: shared types for the write-back arbiter (load FSM states, skid entry)
package scr1_wb_pkg;
  localparam int WB_ADDR_W = 5;
  localparam int WB_XLEN = 32;
  typedef enum logic {WB_IDLE, WB_PEND} wb_ld_state_e;
  typedef struct packed {
    logic vd;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_XLEN-1:0] data;
  } wb_skid_t;
endpackage

// File: rtl/scr1_pipe_wb_arb_if.sv
// scr1_pipe_wb_arb_if: EXU/LSU/MPRF signals around the write-back arbiter
interface scr1_pipe_wb_arb_if #(parameter int ADDR_W = 5, parameter int XLEN = 32);
  logic exu2wb_req;
  logic [ADDR_W-1:0] exu2wb_rd_addr;
  logic [XLEN-1:0] exu2wb_rd_data;
  logic wb2exu_rdy;
  logic exu2wb_ld_issue;
  logic [ADDR_W-1:0] exu2wb_ld_rd_addr;
  logic lsu2wb_ld_vd;
  logic lsu2wb_ld_err;
  logic [XLEN-1:0] lsu2wb_ld_data;
  logic [ADDR_W-1:0] exu2wb_rs1_addr;
  logic [ADDR_W-1:0] exu2wb_rs2_addr;
  logic [ADDR_W-1:0] exu2wb_chk_rd_addr;
  logic wb2exu_rs1_hzd;
  logic wb2exu_rs2_hzd;
  logic wb2exu_rd_hzd;
  logic wb2exu_ld_busy;
  logic wb2mprf_w_req;
  logic [ADDR_W-1:0] wb2mprf_rd_addr;
  logic [XLEN-1:0] wb2mprf_rd_data;
  modport slave (
    input exu2wb_req, exu2wb_rd_addr, exu2wb_rd_data, exu2wb_ld_issue, exu2wb_ld_rd_addr,
          lsu2wb_ld_vd, lsu2wb_ld_err, lsu2wb_ld_data,
          exu2wb_rs1_addr, exu2wb_rs2_addr, exu2wb_chk_rd_addr,
    output wb2exu_rdy, wb2exu_rs1_hzd, wb2exu_rs2_hzd, wb2exu_rd_hzd, wb2exu_ld_busy,
           wb2mprf_w_req, wb2mprf_rd_addr, wb2mprf_rd_data
  );
  modport master (
    output exu2wb_req, exu2wb_rd_addr, exu2wb_rd_data, exu2wb_ld_issue, exu2wb_ld_rd_addr,
           lsu2wb_ld_vd, lsu2wb_ld_err, lsu2wb_ld_data,
           exu2wb_rs1_addr, exu2wb_rs2_addr, exu2wb_chk_rd_addr,
    input wb2exu_rdy, wb2exu_rs1_hzd, wb2exu_rs2_hzd, wb2exu_rd_hzd, wb2exu_ld_busy,
          wb2mprf_w_req, wb2mprf_rd_addr, wb2mprf_rd_data
  );
endinterface

// File: rtl/scr1_pipe_wb_skid.sv
// scr1_pipe_wb_skid: one-entry holding register for an EXU write displaced by a load write
module scr1_pipe_wb_skid import scr1_wb_pkg::*; #(
  parameter int ADDR_W = 5,
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic drain,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0] data,
  output wb_skid_t ent
);
  always_ff @(posedge clk or posedge rst)
    if (rst) ent <= '0;
    else if (load) ent <= '{vd: 1'b1, addr: WB_ADDR_W'(addr), data: WB_XLEN'(data)};
    else if (drain) ent <= '0;
endmodule

// File: rtl/scr1_pipe_wb_arb.sv
// scr1_pipe_wb_arb: shares the MPRF write port between load response, skid entry and EXU
module scr1_pipe_wb_arb import scr1_wb_pkg::*; #(
  parameter int ADDR_W = 5,
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  scr1_pipe_wb_arb_if.slave wb
);
  wb_ld_state_e state;
  logic [ADDR_W-1:0] ld_rd;
  wb_skid_t skid;
  logic [ADDR_W-1:0] skid_rd;
  logic [XLEN-1:0] skid_data;
  logic pend, ld_wr, exu_wr, skid_ld, skid_dr;
  function automatic logic hzd(input logic [ADDR_W-1:0] a, r, s, input logic p, v);
    return (|a) & ((p & (a == r)) | (v & (a == s)));
  endfunction
  assign skid_rd = ADDR_W'(skid.addr);
  assign skid_data = XLEN'(skid.data);
  assign pend = state == WB_PEND;
  assign ld_wr = pend & wb.lsu2wb_ld_vd & ~wb.lsu2wb_ld_err & (|ld_rd);
  assign exu_wr = wb.exu2wb_req & ~skid.vd & (|wb.exu2wb_rd_addr);
  assign skid_ld = exu_wr & ld_wr;
  assign skid_dr = skid.vd & ~ld_wr;
  assign wb.wb2exu_rdy = ~skid.vd;
  assign wb.wb2exu_ld_busy = pend;
  assign wb.wb2mprf_w_req = ld_wr | skid.vd | exu_wr;
  assign wb.wb2mprf_rd_addr = ld_wr ? ld_rd : skid.vd ? skid_rd : exu_wr ? wb.exu2wb_rd_addr : '0;
  assign wb.wb2mprf_rd_data = ld_wr ? wb.lsu2wb_ld_data : skid.vd ? skid_data : exu_wr ? wb.exu2wb_rd_data : '0;
  assign wb.wb2exu_rs1_hzd = hzd(wb.exu2wb_rs1_addr, ld_rd, skid_rd, pend, skid.vd);
  assign wb.wb2exu_rs2_hzd = hzd(wb.exu2wb_rs2_addr, ld_rd, skid_rd, pend, skid.vd);
  assign wb.wb2exu_rd_hzd = hzd(wb.exu2wb_chk_rd_addr, ld_rd, skid_rd, pend, skid.vd);
  scr1_pipe_wb_skid #(.ADDR_W(ADDR_W), .XLEN(XLEN)) u_skid (
    .clk(clk),
    .rst(rst),
    .load(skid_ld),
    .drain(skid_dr),
    .addr(wb.exu2wb_rd_addr),
    .data(wb.exu2wb_rd_data),
    .ent(skid)
  );
  // a response retiring in the same cycle as a new issue keeps the FSM pending on the new rd
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= WB_IDLE;
      ld_rd <= '0;
    end else if (wb.exu2wb_ld_issue & (~pend | wb.lsu2wb_ld_vd)) begin
      state <= WB_PEND;
      ld_rd <= wb.exu2wb_ld_rd_addr;
    end else if (pend & wb.lsu2wb_ld_vd) begin
      state <= WB_IDLE;
      ld_rd <= '0;
    end
  ld_issue_while_pend: assert property (@(posedge clk) disable iff (rst)
    !(pend && wb.exu2wb_ld_issue && !wb.lsu2wb_ld_vd))
    else $warning("load issued while another load is pending");
  ld_vd_while_idle: assert property (@(posedge clk) disable iff (rst)
    !(!pend && wb.lsu2wb_ld_vd))
    else $warning("load response with no load pending");
endmodule

// File: doc/scr1_pipe_wb_arb.md
SCR1_PIPE_WB_ARB -- requirements
Module: scr1_pipe_wb_arb

Interface
REQ-001 Parameter: ADDR_W, default 5 (4 under RVE), MPRF address width.
REQ-002 Parameter: XLEN, default 32, data width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; reset asserts asynchronously and is sampled on clock rise.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- exu2wb_req  in  1  EXU result write request.
- exu2wb_rd_addr  in  ADDR_W  EXU destination.
- exu2wb_rd_data  in  XLEN  EXU result.
- wb2exu_rdy  out  1  EXU write accepted this cycle.
- exu2wb_ld_issue  in  1  load issued to LSU.
- exu2wb_ld_rd_addr  in  ADDR_W  load destination.
- lsu2wb_ld_vd  in  1  load response valid.
- lsu2wb_ld_err  in  1  load response faulted.
- lsu2wb_ld_data  in  XLEN  load data.
- exu2wb_rs1_addr, exu2wb_rs2_addr, exu2wb_chk_rd_addr  in  ADDR_W  addresses to hazard-check.
- wb2exu_rs1_hzd, wb2exu_rs2_hzd, wb2exu_rd_hzd  out  1  per-address hazard.
- wb2exu_ld_busy  out  1  load outstanding.
- wb2mprf_w_req  out  1  MPRF write request.
- wb2mprf_rd_addr  out  ADDR_W  MPRF write address.
- wb2mprf_rd_data  out  XLEN  MPRF write data.

Function
REQ-005 Single MPRF write port SHALL be shared by three sources with fixed priority: load response > skid entry > new EXU write.
REQ-006 wb2exu_rdy SHALL equal ~skid_vd (combinational); an EXU write is accepted iff exu2wb_req & wb2exu_rdy.
REQ-007 Accepted EXU write with no competing source SHALL drive the MPRF write in the same cycle (zero latency, combinational pass-through).
REQ-008 Accepted EXU write colliding with a load write SHALL be captured into a 1-entry skid buffer and written in the first following cycle without a load write.
REQ-009 Writes to address 0 (EXU, skid, or load) SHALL be dropped: no wb2mprf_w_req, no skid occupancy.
REQ-010 Load FSM states: IDLE, PEND; wb2exu_ld_busy = (state == PEND).
REQ-011 IDLE & exu2wb_ld_issue -> PEND, capturing ld_rd_addr (address 0 also captured; the response is consumed but not written).
REQ-012 PEND & lsu2wb_ld_vd -> IDLE; the load write occurs that cycle iff ~lsu2wb_ld_err & rd != 0; on error there is no write and the pending entry clears.
REQ-013 ld_issue in PEND and ld_vd in IDLE SHALL be ignored (protocol violations; SVA-flagged in simulation).
REQ-014 ld_vd and ld_issue in the same PEND cycle: the response retires and the FSM stays PEND with the new rd.
REQ-015 Each hazard output SHALL be high when its nonzero address equals the pending load rd (PEND) or the valid skid rd; address 0 never hazards.
REQ-016 Hazard outputs SHALL be combinational from current state; a write landing this cycle still flags hazard until the next cycle.
REQ-017 wb2mprf_rd_addr/data SHALL be '0 when wb2mprf_w_req is low.
REQ-018 Write ordering per address SHALL match issue order; the EXU guarantees this by honouring wb2exu_rd_hzd.

Reset
REQ-019 On rst: state = IDLE, skid_vd = 0, skid address/data = 0; therefore wb2exu_rdy = 1, busy = 0, all hazards 0, wb2mprf_w_req = 0.
REQ-020 Reset mid-load or with a skid full SHALL discard both; a later ld_vd SHALL be ignored.

Structure
REQ-021 Package scr1_wb_pkg SHALL hold the load FSM enum type and the skid entry struct (vd, addr, data).
REQ-022 Sub-module scr1_pipe_wb_skid SHALL implement the 1-entry skid buffer (load/drain/valid); arbitration and the FSM stay top-level.

Verification
REQ-023 EXU write rd=5, data 0xDEADBEEF, idle -> same-cycle w_req, addr 5, data 0xDEADBEEF; rdy stays 1.
REQ-024 Load issued rd=7; next cycle ld_vd data 0x1234 coincides with EXU write rd=3 data 0xAA -> cycle N writes x7=0x1234; cycle N+1 writes x3=0xAA with rdy=0 in N+1; rdy=1 in N+2.
REQ-025 Load rd=9 pending; rs1=9, rs2=4, chk_rd=9 -> rs1_hzd=1, rs2_hzd=0, rd_hzd=1; after the response all three are 0.
REQ-026 Load rd=6 returns with ld_err=1 -> no MPRF write; busy falls; rs1=6 hazard clears.
REQ-027 EXU write rd=0 data 0xFFFFFFFF, and a load to rd=0 -> no w_req in either case; the load still transitions PEND->IDLE.
REQ-028 rst asserted while PEND with skid full -> all outputs at reset values within the same cycle; a subsequent ld_vd produces no write.
